// File: rtl/uart_tx_arbiter.sv
// Round-robin frame arbiter feeding a single UART transmit FIFO.
// Each grant owns the FIFO for one frame: header {id, len} then len payload bytes.
module uart_tx_arbiter #(
  parameter int NREQ  = 4,
  parameter int DBIT  = 8,
  parameter int LEN_W = 4,
  parameter int ID_W  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic [NREQ*DBIT-1:0]  req_data,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       data_rd,
  output logic [NREQ-1:0]       frame_done,
  input  logic                  tx_full,
  output logic                  wr_uart,
  output logic [DBIT-1:0]       w_data,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   cur_id, cur_id_nxt;
  logic [ID_W-1:0]   last_id, last_id_nxt;
  logic [LEN_W-1:0]  cur_len, cur_len_nxt;
  logic [LEN_W-1:0]  cnt, cnt_nxt;
  logic [NREQ-1:0]   gnt_nxt, frame_done_nxt;
  logic              busy_nxt;
  logic [DBIT-1:0]   hdr_byte;

  logic [LEN_W-1:0]  len_arr  [NREQ];
  logic [DBIT-1:0]   data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign len_arr[g]  = req_len[g*LEN_W +: LEN_W];
    assign data_arr[g] = req_data[g*DBIT +: DBIT];
  end

  // First set request after the last served id, wrapping modulo NREQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [ID_W-1:0] last);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && r[idx[ID_W-1:0]]) begin
        pick  = idx[ID_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [NREQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  always_comb begin
    hdr_byte = '0;
    hdr_byte[ID_W+LEN_W-1:0] = {cur_id, cur_len};
  end

  always_comb begin
    state_nxt   = state;
    cur_id_nxt  = cur_id;
    cur_len_nxt = cur_len;
    cnt_nxt     = cnt;
    last_id_nxt = last_id;
    wr_uart     = 1'b0;
    w_data      = '0;
    data_rd     = '0;
    case (state)
      IDLE: begin
        if (|req) begin
          cur_id_nxt  = rr_pick(req, last_id);
          cur_len_nxt = len_arr[cur_id_nxt];
          state_nxt   = HDR;
        end
      end
      HDR: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          w_data  = hdr_byte;
          if (cur_len == '0) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt   = cur_len;
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          w_data  = data_arr[cur_id];
          data_rd = onehot(cur_id);
          if (cnt != '0) cnt_nxt = cnt - LEN_W'(1);
          if (cnt <= LEN_W'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        last_id_nxt = cur_id;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs are derived from the next state so they line up with it.
  always_comb begin
    busy_nxt       = (state_nxt != IDLE);
    gnt_nxt        = (state_nxt == IDLE) ? '0 : onehot(cur_id_nxt);
    frame_done_nxt = (state_nxt == DONE) ? onehot(cur_id_nxt) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cur_id     <= '0;
      cur_len    <= '0;
      cnt        <= '0;
      last_id    <= ID_W'(NREQ - 1);
      gnt        <= '0;
      frame_done <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_id     <= cur_id_nxt;
      cur_len    <= cur_len_nxt;
      cnt        <= cnt_nxt;
      last_id    <= last_id_nxt;
      gnt        <= gnt_nxt;
      frame_done <= frame_done_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected writes and frame_done pulses are
// queued by the stimulus and consumed by an independent negedge monitor.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic [31:0] req_data;
  logic [3:0]  gnt, data_rd, frame_done;
  logic        tx_full;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic        busy;

  uart_tx_arbiter #(.NREQ(4), .DBIT(8), .LEN_W(4), .ID_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_len    (req_len),
    .req_data   (req_data),
    .gnt        (gnt),
    .data_rd    (data_rd),
    .frame_done (frame_done),
    .tx_full    (tx_full),
    .wr_uart    (wr_uart),
    .w_data     (w_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] gnt;
    logic [3:0] rd;
  } wr_t;

  wr_t        wr_q[$];
  logic [3:0] done_q[$];
  int         ptr[4];
  int         exp_ptr[4];
  int         n_checks = 0;
  int         n_fail   = 0;

  // Requester i presents byte {A+i, pop_index+1}; a pop advances to the next one.
  function automatic logic [7:0] byte_of(input int i, input int p);
    return {4'(10 + i), 4'(p + 1)};
  endfunction

  function automatic logic [3:0] oh(input int id);
    return 4'(1 << id);
  endfunction

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (data_rd[i]) ptr[i] <= ptr[i] + 1;

  assign req_data = {byte_of(3, ptr[3]), byte_of(2, ptr[2]),
                     byte_of(1, ptr[1]), byte_of(0, ptr[0])};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int id, input int len, input int npay);
    wr_q.push_back('{data: {2'(id), 4'(len)} | 8'h00, gnt: oh(id), rd: 4'b0000});
    for (int k = 0; k < npay; k++) begin
      wr_q.push_back('{data: byte_of(id, exp_ptr[id]), gnt: oh(id), rd: oh(id)});
      exp_ptr[id]++;
    end
  endtask

  // Single-requester frame; full_mask bit c holds tx_full for the cycle after edge c.
  task automatic run_frame(input int id, input int len, input logic [31:0] full_mask,
                           input int exp_done);
    bit seen;
    push_frame(id, len, len);
    done_q.push_back(oh(id));
    req     = oh(id);
    req_len = 16'(len) << (4 * id);
    seen    = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      tick(1);
      if (c == 1) begin
        req     = 4'b0000;
        req_len = 16'h7777;
      end
      tx_full = (c < 32) ? full_mask[5'(c)] : 1'b0;
      if (|frame_done) begin
        seen = 1'b1;
        chk($sformatf("done_cycle_id%0d", id), 64'(c), 64'(exp_done));
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout_id%0d: got no frame_done expected pulse within 40 cycles", id);
    end
    tx_full = 1'b0;
    tick(1);
  endtask

  initial begin
    wr_t        e;
    logic [3:0] d;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (wr_uart) begin
          if (wr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got %0h expected no write", w_data);
          end else begin
            e = wr_q.pop_front();
            chk("write", 64'({w_data, gnt, data_rd, busy}), 64'({e.data, e.gnt, e.rd, 1'b1}));
          end
        end
        if (tx_full) chk("stall_quiet", 64'({wr_uart, data_rd}), 64'd0);
        if (|frame_done) begin
          if (done_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got %0h expected none", frame_done);
          end else begin
            d = done_q.pop_front();
            chk("frame_done", 64'({frame_done, gnt, busy}), 64'({d, d, 1'b1}));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[5];
    order   = '{0, 1, 2, 3, 0};
    reset   = 1'b1;
    req     = '0;
    req_len = '0;
    tx_full = 1'b0;
    #2 reset = 1'b0;
    #1 chk("reset_outputs", 64'({gnt, data_rd, frame_done, wr_uart, w_data, busy}), 64'd0);
    tick(2);
    reset = 1'b1;
    tick(1);

    // Requester 0, three payload bytes, no back-pressure.
    run_frame(0, 3, 32'h0, 5);
    chk("idle_after_frame", 64'(busy), 64'd0);

    // All requesters pending, length 1 each: round-robin 0,1,2,3,0 from reset.
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    req_len = 16'h1111;
    for (int k = 0; k < 5; k++) begin
      push_frame(order[k], 1, 1);
      done_q.push_back(oh(order[k]));
    end
    req = 4'b1111;
    for (int c = 1; c <= 17; c++) begin
      tick(1);
      if ((c - 1) % 4 == 0) chk("rr_gnt", 64'(gnt), 64'(oh(order[(c - 1) / 4])));
    end
    req = 4'b0000;
    tick(3);
    chk("rr_idle", 64'(busy), 64'd0);

    // Zero-length frame: header only.
    run_frame(2, 0, 32'h0, 2);

    // Back-pressure on the 2nd and 4th write attempts.
    run_frame(1, 4, 32'h14, 8);

    // Long frame aborted by reset after five payload bytes.
    push_frame(3, 15, 5);
    req     = 4'b1000;
    req_len = 16'hF000;
    tick(1);
    req = 4'b0000;
    tick(6);
    reset = 1'b0;
    #1 chk("abort_outputs", 64'({gnt, data_rd, frame_done, wr_uart, w_data, busy}), 64'd0);
    chk("abort_bytes_left", 64'(wr_q.size()), 64'd0);
    tick(2);
    chk("abort_no_done", 64'({frame_done, busy}), 64'd0);
    reset = 1'b1;
    tick(1);
    run_frame(3, 15, 32'h0, 17);

    // Length sampled at grant; later req_len changes are ignored.
    run_frame(0, 2, 32'h0, 4);

    tick(2);
    chk("wr_queue_empty", 64'(wr_q.size()), 64'd0);
    chk("done_queue_empty", 64'(done_q.size()), 64'd0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("pop_count_%0d", i), 64'(ptr[i]), 64'(exp_ptr[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
